// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter. It inhibits the bus, sends the start bit,
// then shifts out data, parity and stop on the device clock, and finally checks the ACK.
module ps2_host_tx #(
   parameter int unsigned INHIBIT_CYC = 12000,
   parameter int unsigned TIMEOUT_CYC = 2000000,
   parameter int unsigned FILT_CYC    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] tx_data,
   input  logic       tx_vld,
   output logic       tx_rdy,
   input  logic       ps2_clk_in,
   input  logic       ps2_data_in,
   output logic       ps2_clk_oe,
   output logic       ps2_data_oe,
   output logic       rx_block,
   output logic       done,
   output logic       err,
   output logic [1:0] err_code
);

   localparam int unsigned CntMax = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
   localparam int unsigned CntW   = $clog2(CntMax + 1);
   localparam int unsigned FiltW  = $clog2(FILT_CYC + 1);

   typedef enum logic [2:0] {StIdle, StInhibit, StStart, StSend, StAck, StWaitIdle} state_e;

   // Line index 0 = PS/2 clock, 1 = PS/2 data
   logic [1:0]            sync1_q, sync2_q, filt_q, filt_d;
   logic [1:0][FiltW-1:0] fcnt_q, fcnt_d;
   logic                  fe_q;

   always_comb begin
      filt_d = filt_q;
      fcnt_d = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync2_q[i] != filt_q[i]) begin
            if (fcnt_q[i] == FiltW'(FILT_CYC - 1)) filt_d[i] = sync2_q[i];
            else                                   fcnt_d[i] = fcnt_q[i] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= 2'b11;
         sync2_q <= 2'b11;
         filt_q  <= 2'b11;
         fcnt_q  <= '0;
         fe_q    <= 1'b0;
      end else begin
         sync1_q <= {ps2_data_in, ps2_clk_in};
         sync2_q <= sync1_q;
         filt_q  <= filt_d;
         fcnt_q  <= fcnt_d;
         fe_q    <= filt_q[0] & ~filt_d[0];
      end
   end

   state_e          state_q;
   logic [CntW-1:0] cnt_q;
   logic [3:0]      idx_q;
   logic [7:0]      shift_q;
   logic            par_q, nack_q;
   logic            clk_oe_q, data_oe_q, rdy_q, blk_q, done_q, err_q;
   logic [1:0]      code_q;
   logic            in_xfer, timeout, cur_bit;

   assign in_xfer = (state_q == StSend) || (state_q == StAck) || (state_q == StWaitIdle);
   assign timeout = in_xfer && (cnt_q == CntW'(TIMEOUT_CYC - 1));
   assign cur_bit = idx_q[3] ? par_q : shift_q[idx_q[2:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         idx_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         nack_q    <= 1'b0;
         clk_oe_q  <= 1'b0;
         data_oe_q <= 1'b0;
         rdy_q     <= 1'b1;
         blk_q     <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         code_q    <= 2'b00;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         // Timeout overrides any same-cycle falling edge
         if (timeout) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            code_q    <= 2'b10;
            rdy_q     <= 1'b1;
            blk_q     <= 1'b0;
            state_q   <= StIdle;
         end else begin
            if (in_xfer) cnt_q <= cnt_q + 1'b1;
            unique case (state_q)
               StIdle: begin
                  if (tx_vld) begin
                     shift_q  <= tx_data;
                     par_q    <= ~^tx_data;
                     cnt_q    <= '0;
                     clk_oe_q <= 1'b1;
                     rdy_q    <= 1'b0;
                     blk_q    <= 1'b1;
                     state_q  <= StInhibit;
                  end
               end
               StInhibit: begin
                  if (cnt_q == CntW'(INHIBIT_CYC - 1)) begin
                     data_oe_q <= 1'b1;
                     state_q   <= StStart;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
               StStart: begin
                  clk_oe_q <= 1'b0;
                  idx_q    <= '0;
                  cnt_q    <= '0;
                  state_q  <= StSend;
               end
               StSend: begin
                  if (fe_q) begin
                     if (idx_q == 4'd9) begin
                        data_oe_q <= 1'b0;
                        state_q   <= StAck;
                     end else begin
                        data_oe_q <= ~cur_bit;
                        idx_q     <= idx_q + 1'b1;
                     end
                  end
               end
               StAck: begin
                  if (fe_q) begin
                     nack_q  <= filt_q[1];
                     state_q <= StWaitIdle;
                  end
               end
               StWaitIdle: begin
                  if (filt_q == 2'b11) begin
                     done_q  <= ~nack_q;
                     err_q   <= nack_q;
                     if (nack_q) code_q <= 2'b01;
                     rdy_q   <= 1'b1;
                     blk_q   <= 1'b0;
                     state_q <= StIdle;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign tx_rdy      = rdy_q;
   assign ps2_clk_oe  = clk_oe_q;
   assign ps2_data_oe = data_oe_q;
   assign rx_block    = blk_q;
   assign done        = done_q;
   assign err         = err_q;
   assign err_code    = code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx against a simple open-drain PS/2 device model.
`timescale 1ns / 1ps
module tb_ps2_host_tx;

   localparam int unsigned InhibitCyc = 50;
   localparam int unsigned TimeoutCyc = 5000;
   localparam int unsigned FiltCyc    = 2;
   // Device clock half-period in system cycles, short enough to finish inside the timeout
   localparam int Half = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] tx_data;
   logic       tx_vld;
   logic       tx_rdy;
   logic       ps2_clk_oe, ps2_data_oe, rx_block, done, err;
   logic [1:0] err_code;
   logic       dev_clk_low, dev_data_low;
   logic       ps2_clk_pin, ps2_data_pin;

   assign ps2_clk_pin  = ~(ps2_clk_oe | dev_clk_low);
   assign ps2_data_pin = ~(ps2_data_oe | dev_data_low);

   ps2_host_tx #(
      .INHIBIT_CYC(InhibitCyc),
      .TIMEOUT_CYC(TimeoutCyc),
      .FILT_CYC   (FiltCyc)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_vld     (tx_vld),
      .tx_rdy     (tx_rdy),
      .ps2_clk_in (ps2_clk_pin),
      .ps2_data_in(ps2_data_pin),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .rx_block   (rx_block),
      .done       (done),
      .err        (err),
      .err_code   (err_code)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0, err_cnt = 0, both_cnt = 0;
   int d0, e0, n, cyc, hi;
   logic [9:0] bits;

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (err) err_cnt++;
      if (done && err) both_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int k = 0;
      @(negedge clk);
      while (!tx_rdy && k < 20000) begin
         @(negedge clk);
         k++;
      end
      check("rdy_wait", 32'(tx_rdy), 32'd1);
      tx_data = b;
      tx_vld  = 1'b1;
      @(negedge clk);
      tx_vld  = 1'b0;
   endtask

   // Waits for the host to release clock with the start bit down, then clocks n_edges pulses
   task automatic dev_run(input int n_edges, input bit do_ack, output logic [9:0] rx);
      int k = 0;
      rx = '0;
      while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && k < 20000) begin
         @(negedge clk);
         k++;
      end
      check("dev_req", 32'(k < 20000), 32'd1);
      if (k < 20000) begin
         repeat (10) @(negedge clk);
         for (int i = 0; i < 10 && i < n_edges; i++) begin
            dev_clk_low = 1'b1;
            repeat (Half) @(negedge clk);
            dev_clk_low = 1'b0;
            rx[i] = ps2_data_pin;
            repeat (Half) @(negedge clk);
         end
         if (n_edges > 10) begin
            if (do_ack) dev_data_low = 1'b1;
            repeat (5) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (Half) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (Half) @(negedge clk);
            dev_data_low = 1'b0;
         end
      end
   endtask

   task automatic wait_pulse();
      int k = 0;
      while (done_cnt == d0 && err_cnt == e0 && k < 20000) begin
         @(negedge clk);
         k++;
      end
      check("pulse_seen", 32'(k < 20000), 32'd1);
      repeat (3) @(negedge clk);
   endtask

   task automatic ack_xfer(input logic [7:0] b, input logic [9:0] exp_bits, input string tag);
      d0 = done_cnt;
      e0 = err_cnt;
      send(b);
      dev_run(11, 1'b1, bits);
      wait_pulse();
      check({tag, "_bits"}, 32'(bits), 32'(exp_bits));
      check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
      check({tag, "_err"}, 32'(err_cnt - e0), 32'd0);
   endtask

   initial begin
      rst = 1'b1;
      tx_data = 8'h00;
      tx_vld = 1'b0;
      dev_clk_low = 1'b0;
      dev_data_low = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_rdy", 32'(tx_rdy), 32'd1);
      check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("rst_data_oe", 32'(ps2_data_oe), 32'd0);
      check("rst_block", 32'(rx_block), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_code", 32'(err_code), 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // 0xED with ACK, including inhibit and start-bit timing
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'hED);
      fork
         dev_run(11, 1'b1, bits);
         begin
            hi = 0;
            n = 0;
            check("busy_block", 32'(rx_block), 32'd1);
            while (ps2_clk_oe && !ps2_data_oe && n < 1000) begin
               hi++;
               @(negedge clk);
               n++;
            end
            check("inhibit_len", 32'(hi), 32'd50);
            check("start_clk_oe", 32'(ps2_clk_oe), 32'd1);
            check("start_data_oe", 32'(ps2_data_oe), 32'd1);
            @(negedge clk);
            check("send_clk_oe", 32'(ps2_clk_oe), 32'd0);
            check("send_data_oe", 32'(ps2_data_oe), 32'd1);
         end
      join
      wait_pulse();
      check("ed_bits", 32'(bits), 32'h3ED);
      check("ed_done", 32'(done_cnt - d0), 32'd1);
      check("ed_err", 32'(err_cnt - e0), 32'd0);
      check("ed_rdy", 32'(tx_rdy), 32'd1);
      check("ed_block", 32'(rx_block), 32'd0);

      ack_xfer(8'h01, 10'h201, "x01");
      ack_xfer(8'h00, 10'h300, "x00");

      // No ACK from the device
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'hF3);
      dev_run(11, 1'b0, bits);
      wait_pulse();
      check("nack_bits", 32'(bits), 32'h3F3);
      check("nack_err", 32'(err_cnt - e0), 32'd1);
      check("nack_done", 32'(done_cnt - d0), 32'd0);
      check("nack_code", 32'(err_code), 32'd1);
      check("nack_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("nack_data_oe", 32'(ps2_data_oe), 32'd0);

      // Device never clocks: timeout measured from first cycle in SEND
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'hF4);
      n = 0;
      while (ps2_clk_oe && n < 1000) begin
         @(negedge clk);
         n++;
      end
      cyc = 0;
      while (!err && cyc < 10000) begin
         @(negedge clk);
         cyc++;
      end
      check("to_cycles", 32'(cyc), 32'd5000);
      check("to_code", 32'(err_code), 32'd2);
      check("to_done", 32'(done), 32'd0);
      @(negedge clk);
      check("to_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("to_data_oe", 32'(ps2_data_oe), 32'd0);
      check("to_rdy", 32'(tx_rdy), 32'd1);

      // Async reset mid-transfer after four device clock edges
      repeat (5) @(negedge clk);
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'h00);
      dev_run(4, 1'b1, bits);
      check("mid_block", 32'(rx_block), 32'd1);
      check("mid_data_oe", 32'(ps2_data_oe), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("arst_data_oe", 32'(ps2_data_oe), 32'd0);
      check("arst_rdy", 32'(tx_rdy), 32'd1);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("arst_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
      ack_xfer(8'hFF, 10'h3FF, "xff");

      // tx_vld during a transfer is ignored
      d0 = done_cnt;
      e0 = err_cnt;
      send(8'hED);
      fork
         dev_run(11, 1'b1, bits);
         begin
            repeat (150) @(negedge clk);
            tx_data = 8'hAA;
            tx_vld  = 1'b1;
            @(negedge clk);
            tx_vld  = 1'b0;
         end
      join
      wait_pulse();
      check("busy_bits", 32'(bits), 32'h3ED);
      hi = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (ps2_clk_oe || ps2_data_oe) hi++;
      end
      check("busy_no_requeue", 32'(hi), 32'd0);
      check("busy_done", 32'(done_cnt - d0), 32'd1);
      check("busy_err", 32'(err_cnt - e0), 32'd0);
      check("never_both", 32'(both_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
